// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and constants for the UART transmit path.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } tx_sched_state_t;

    localparam logic [7:0] UART_SYNC_DEFAULT = 8'hA5;
    localparam int         FRAME_BYTES_HDR   = 6;
    localparam int         FRAME_BYTES_RAW   = 4;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick, searching upward from last+1.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0] req,
    input  logic [2:0]      last_grant,
    output logic [N_CH-1:0] grant,
    output logic [2:0]      grant_idx,
    output logic            grant_valid
);

    int w_best_dist;
    int w_best_ch;
    int w_dist;

    always_comb begin
        w_best_dist = N_CH;
        w_best_ch   = 0;
        w_dist      = 0;
        grant       = '0;
        // Distance of channel c from the slot after last_grant, with wrap.
        for (int c = 0; c < N_CH; c++) begin
            w_dist = (c + 8 * N_CH - int'(last_grant) - 1) % N_CH;
            if (req[c] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                w_best_ch   = c;
            end
        end
        for (int c = 0; c < N_CH; c++) begin
            grant[c] = (w_best_dist < N_CH) && (c == w_best_ch);
        end
        grant_idx   = 3'(w_best_ch);
        grant_valid = (w_best_dist < N_CH);
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler
// Purpose  : Shares one byte-wide UART among N_CH 32-bit word producers.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int         N_CH      = 4,
    parameter bit         HDR_EN    = 1'b1,
    parameter logic [7:0] SYNC_BYTE = UART_SYNC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CH-1:0]    req_valid,
    input  logic [N_CH*32-1:0] req_data,
    output logic [N_CH-1:0]    req_ready,
    input  logic               tx_busy,
    output logic [7:0]         tx_data,
    output logic               tx_start,
    output logic [2:0]         grant_ch,
    output logic               frame_active
);

    localparam logic [2:0] c_LAST_IDX =
        3'((HDR_EN ? FRAME_BYTES_HDR : FRAME_BYTES_RAW) - 1);
    localparam logic [2:0] c_RESET_GRANT = 3'(N_CH - 1);

    tx_sched_state_t r_state;
    tx_sched_state_t w_state_next;
    logic [2:0]      r_byte_idx;
    logic [2:0]      r_last_grant;
    logic [2:0]      r_grant_ch;
    logic [31:0]     r_word;
    logic [7:0]      r_tx_data;
    logic            r_tx_start;

    logic [N_CH-1:0] w_arb_grant;
    logic [2:0]      w_arb_idx;
    logic            w_arb_valid;
    logic            w_accept;
    logic            w_send;
    logic [31:0]     w_sel_word;
    logic [1:0]      w_data_idx;
    logic [7:0]      w_word_byte;
    logic [7:0]      w_frame_byte;

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .req         (req_valid),
        .last_grant  (r_last_grant),
        .grant       (w_arb_grant),
        .grant_idx   (w_arb_idx),
        .grant_valid (w_arb_valid)
    );

    // Reset wins over a same-cycle request, so ready is masked by rst.
    assign w_accept  = (r_state == IDLE) && w_arb_valid && !rst;
    assign req_ready = ((r_state == IDLE) && !rst) ? w_arb_grant : '0;

    always_comb begin
        w_sel_word = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (w_arb_grant[c]) begin
                w_sel_word = req_data[32*c +: 32];
            end
        end
    end

    always_comb begin
        w_data_idx = HDR_EN ? 2'(r_byte_idx - 3'd2) : r_byte_idx[1:0];
        case (w_data_idx)
            2'd0:    w_word_byte = r_word[7:0];
            2'd1:    w_word_byte = r_word[15:8];
            2'd2:    w_word_byte = r_word[23:16];
            default: w_word_byte = r_word[31:24];
        endcase
        if (HDR_EN && (r_byte_idx == 3'd0)) begin
            w_frame_byte = SYNC_BYTE;
        end else if (HDR_EN && (r_byte_idx == 3'd1)) begin
            w_frame_byte = {5'b0, r_grant_ch};
        end else begin
            w_frame_byte = w_word_byte;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_send       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = SEND;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    w_send       = 1'b1;
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                // The UART raises tx_busy late, so this cycle never samples it.
                w_state_next = (r_byte_idx == c_LAST_IDX) ? IDLE : SEND;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_byte_idx   <= 3'd0;
            r_last_grant <= c_RESET_GRANT;
            r_grant_ch   <= 3'd0;
            r_word       <= 32'd0;
            r_tx_data    <= 8'd0;
            r_tx_start   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_tx_start <= w_send;
            if (w_send) begin
                r_tx_data <= w_frame_byte;
            end
            if (w_accept) begin
                r_word       <= w_sel_word;
                r_grant_ch   <= w_arb_idx;
                r_last_grant <= w_arb_idx;
                r_byte_idx   <= 3'd0;
            end else if ((r_state == HOLD) && (r_byte_idx != c_LAST_IDX)) begin
                r_byte_idx <= r_byte_idx + 3'd1;
            end
        end
    end

    assign tx_data      = r_tx_data;
    assign tx_start     = r_tx_start;
    assign grant_ch     = r_grant_ch;
    assign frame_active = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_scheduler
// Purpose  : Randomized and directed bench with a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;

    localparam int N_CH = 4;
    localparam int FLEN = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [N_CH-1:0]    req_valid, req_ready;
    logic [N_CH*32-1:0] req_data;
    logic               tx_busy, tx_start, frame_active;
    logic [7:0]         tx_data;
    logic [2:0]         grant_ch;

    logic [N_CH-1:0]    valid_b, ready_b;
    logic [N_CH*32-1:0] data_b;
    logic               busy_b, start_b, fa_b;
    logic [7:0]         txd_b;
    logic [2:0]         grant_b;

    uart_tx_scheduler #(.N_CH(N_CH), .HDR_EN(1'b1), .SYNC_BYTE(8'hA5)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_busy(tx_busy), .tx_data(tx_data),
        .tx_start(tx_start), .grant_ch(grant_ch), .frame_active(frame_active));

    uart_tx_scheduler #(.N_CH(N_CH), .HDR_EN(1'b0), .SYNC_BYTE(8'hA5)) dut_b (
        .clk(clk), .rst(rst), .req_valid(valid_b), .req_data(data_b),
        .req_ready(ready_b), .tx_busy(busy_b), .tx_data(txd_b),
        .tx_start(start_b), .grant_ch(grant_b), .frame_active(fa_b));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // UART models: busy rises the cycle after tx_start and lasts busy_len cycles.
    int   busy_cnt = 0, busy_len = 10, busy_cnt_b = 0;
    logic force_busy = 1'b0;
    assign tx_busy = (busy_cnt != 0) || force_busy;
    assign busy_b  = (busy_cnt_b != 0);

    always @(posedge clk) begin
        if (rst)                busy_cnt <= 0;
        else if (tx_start)      busy_cnt <= busy_len;
        else if (busy_cnt > 0)  busy_cnt <= busy_cnt - 1;
        if (rst)                busy_cnt_b <= 0;
        else if (start_b)       busy_cnt_b <= 3;
        else if (busy_cnt_b > 0) busy_cnt_b <= busy_cnt_b - 1;
    end

    // Reference model state: bytes still owed on the wire, round-robin pointer.
    logic [7:0]      exp_q[$];
    logic [7:0]      byte_log[$];
    int              glog[$];
    int              model_last = N_CH - 1;
    int              pending_grant = -1;
    bit              post_rst = 1'b0;
    logic            prev_busy = 1'b0;
    int              cyc = 0, acc_cyc = 0, last_lat = -1, ready_cnt = 0, n_starts = 0;
    logic [N_CH-1:0] acc_mask = '0;

    function automatic int rr_pick(input logic [N_CH-1:0] v, input int last);
        int c;
        for (int i = 1; i <= N_CH; i++) begin
            c = (last + i) % N_CH;
            if (((v >> c) & 1) != 0) return c;
        end
        return -1;
    endfunction

    task automatic push_frame(input int ch, input logic [31:0] w);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(ch));
        for (int k = 0; k < 4; k++) exp_q.push_back(8'(w >> (8 * k)));
    endtask

    always @(negedge clk) begin : mon
        logic [N_CH-1:0] exp_ready;
        int              ch;
        logic [7:0]      b;
        cyc++;
        if (rst) begin
            check("rst_ready", 32'(req_ready), 32'd0);
            exp_q.delete();
            model_last    = N_CH - 1;
            post_rst      = 1'b1;
            pending_grant = -1;
        end else begin
            if (post_rst) begin
                check("rst_tx_start", 32'(tx_start), 32'd0);
                check("rst_frame_active", 32'(frame_active), 32'd0);
                check("rst_grant_ch", 32'(grant_ch), 32'd0);
                post_rst = 1'b0;
            end
            if (pending_grant >= 0) begin
                check("grant_ch", 32'(grant_ch), 32'(pending_grant));
                pending_grant = -1;
            end
            check("frame_active", 32'(frame_active), 32'((exp_q.size() != 0) || tx_start));
            if (tx_start) begin
                n_starts++;
                byte_log.push_back(tx_data);
                check("start_while_busy", 32'(prev_busy), 32'd0);
                if (exp_q.size() == 0) begin
                    check("spurious_tx_start", 32'(tx_start), 32'd0);
                end else begin
                    if (exp_q.size() == FLEN) last_lat = cyc - acc_cyc;
                    b = exp_q.pop_front();
                    check("tx_data", 32'(tx_data), 32'(b));
                end
            end
            exp_ready = '0;
            ch        = -1;
            if (exp_q.size() == 0 && !tx_start && req_valid != 0) begin
                ch        = rr_pick(req_valid, model_last);
                exp_ready = (N_CH'(1)) << ch;
            end
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            if (req_ready != 0) ready_cnt++;
            if (ch >= 0) begin
                push_frame(ch, 32'(req_data >> (32 * ch)));
                model_last    = ch;
                pending_grant = ch;
                glog.push_back(ch);
                acc_cyc       = cyc;
                acc_mask      = exp_ready;
            end
        end
        prev_busy = tx_busy;
    end

    logic [7:0] blog_b[$];
    logic [N_CH-1:0] acc_b = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (start_b) blog_b.push_back(txd_b);
            if (ready_b != 0) acc_b = ready_b;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req_valid = '1; valid_b = '1;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = '0; valid_b = '0; acc_mask = '0;
    endtask

    // Drop each channel's valid once accepted; stop when all frames are out.
    task automatic serve(input int max_cyc, input string tag);
        int n;
        for (n = 0; n < max_cyc; n++) begin
            @(posedge clk); #1;
            req_valid = req_valid & ~acc_mask;
            acc_mask  = '0;
            if (req_valid == 0 && exp_q.size() == 0 && !frame_active) break;
        end
        check({tag, "_done"}, 32'(n < max_cyc), 32'd1);
    endtask

    initial begin
        int              s0, n;
        logic [7:0]      td;
        rst = 1'b1; req_valid = '0; req_data = '0; valid_b = '0; data_b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single float word on ch0 with header.
        do_reset();
        byte_log.delete(); ready_cnt = 0;
        req_data[31:0] = 32'h3F80_0000;
        req_valid = 4'b0001;
        serve(300, "t1");
        check("t1_nbytes", 32'(byte_log.size()), 32'd6);
        check("t1_b0", 32'(byte_log[0]), 32'hA5);
        check("t1_b1", 32'(byte_log[1]), 32'h00);
        check("t1_b4", 32'(byte_log[4]), 32'h80);
        check("t1_b5", 32'(byte_log[5]), 32'h3F);
        check("t1_ready_cycles", 32'(ready_cnt), 32'd1);
        check("t1_latency", 32'(last_lat), 32'd2);

        // All channels at once: strict channel order.
        do_reset();
        byte_log.delete(); glog.delete();
        req_data = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        req_valid = 4'b1111;
        serve(1000, "t2");
        check("t2_frames", 32'(glog.size()), 32'd4);
        for (int i = 0; i < 4; i++) check("t2_order", 32'(glog[i]), 32'(i));
        check("t2_nbytes", 32'(byte_log.size()), 32'd24);
        check("t2_f2_sync", 32'(byte_log[6]), 32'hA5);
        check("t2_f2_ch", 32'(byte_log[7]), 32'h01);

        // tx_busy stuck high in SEND.
        do_reset();
        force_busy = 1'b1;
        req_data[31:0] = 32'h1234_5678;
        req_valid = 4'b0001;
        repeat (3) begin
            @(posedge clk); #1;
            req_valid = req_valid & ~acc_mask; acc_mask = '0;
        end
        s0 = n_starts; td = tx_data;
        repeat (50) @(posedge clk);
        #1;
        check("t4_no_start", 32'(n_starts - s0), 32'd0);
        check("t4_data_held", 32'(tx_data), 32'(td));
        check("t4_active", 32'(frame_active), 32'd1);
        force_busy = 1'b0;
        @(posedge clk); @(negedge clk);
        check("t4_release_start", 32'(tx_start), 32'd1);
        check("t4_release_byte", 32'(tx_data), 32'hA5);
        serve(300, "t4");

        // Reset after the third byte aborts the frame.
        do_reset();
        req_data = {32'h0, 32'h0, 32'hCAFE_F00D, 32'h0BAD_BEEF};
        req_valid = 4'b0001;
        s0 = n_starts;
        for (n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            req_valid = req_valid & ~acc_mask; acc_mask = '0;
            if (n_starts - s0 >= 3) break;
        end
        check("t5_three_bytes", 32'(n_starts - s0), 32'd3);
        rst = 1'b1; req_valid = 4'b0010; byte_log.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        serve(300, "t5");
        check("t5_nbytes", 32'(byte_log.size()), 32'd6);
        check("t5_b0", 32'(byte_log[0]), 32'hA5);
        check("t5_b1", 32'(byte_log[1]), 32'h01);

        // ch1 raises valid during ch3's frame and is granted next.
        do_reset();
        glog.delete();
        req_data = {32'h3333_0003, 32'h0, 32'h1111_0001, 32'h0};
        req_valid = 4'b1000;
        for (n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            if (acc_mask != 0) begin req_valid = '0; acc_mask = '0; break; end
        end
        repeat (5) @(posedge clk);
        #1 req_valid = 4'b0010;
        serve(400, "t6");
        check("t6_frames", 32'(glog.size()), 32'd2);
        check("t6_first", 32'(glog[0]), 32'd3);
        check("t6_second", 32'(glog[1]), 32'd1);

        // Data-only instance on ch2.
        blog_b.delete(); acc_b = '0;
        data_b = '0;
        data_b[95:64] = 32'hDEAD_BEEF;
        valid_b = 4'b0100;
        for (n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            if (acc_b != 0) begin valid_b = '0; break; end
        end
        for (n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (blog_b.size() >= 4 && !fa_b) break;
        end
        repeat (20) @(posedge clk);
        #1;
        check("t3_accept", 32'(acc_b), 32'h4);
        check("t3_nbytes", 32'(blog_b.size()), 32'd4);
        check("t3_b0", 32'(blog_b[0]), 32'hEF);
        check("t3_b1", 32'(blog_b[1]), 32'hBE);
        check("t3_b2", 32'(blog_b[2]), 32'hAD);
        check("t3_b3", 32'(blog_b[3]), 32'hDE);
        check("t3_grant", 32'(grant_b), 32'd2);

        // Random traffic, random UART busy times and occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            acc_mask = '0;
            busy_len = int'($urandom_range(1, 12));
            if ($urandom_range(0, 1) == 0) req_valid = N_CH'($urandom);
            for (int c = 0; c < N_CH; c++) req_data[32*c +: 32] = $urandom;
            rst = ($urandom_range(0, 199) == 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; req_valid = '0;
        serve(300, "rand");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
